umi_rr_arbiter: RTL and testbench
=================================

UMI_RR_ARBITER -- requirements
Module: umi_rr_arbiter

Interface
REQ-001 Parameter N, default 4, number of requesters (N >= 2).
REQ-002 Parameter CW, default 8, width of hold-timeout counter.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous active-high reset.
REQ-005 mode  input  1  0 = fixed priority (index 0 highest), 1 = round-robin.
REQ-006 umi_in_mask  input  N  1 = requester excluded from new arbitration.
REQ-007 umi_in_valid  input  N  per-requester valid.
REQ-008 umi_in_last  input  N  per-requester last-beat flag, qualified by valid.
REQ-009 umi_in_ready  output  N  per-requester ready.
REQ-010 umi_out_ready  input  1  downstream ready.
REQ-011 umi_out_valid  output  1  downstream valid.
REQ-012 umi_grant  output  N  one-hot registered grant (drives external mux).
REQ-013 timeout  input  CW  max idle cycles with lock held; 0 = disabled.
REQ-014 umi_abort  output  1  one-cycle pulse when a lock is broken by timeout.

Function
REQ-015 States: IDLE (umi_grant = 0) and LOCK (umi_grant one-hot).
REQ-016 Eligible set E = umi_in_valid & ~umi_in_mask.
REQ-017 IDLE: if E != 0, at next edge load umi_grant with winner, go LOCK; else stay IDLE.
REQ-018 Arbitration latency: first grant one cycle after valid assertion; no combinational valid-to-grant path.
REQ-019 mode=0 winner: lowest set index of E.
REQ-020 mode=1 winner: first set index of E at or above pointer P, wrapping N-1 -> 0.
REQ-021 P resets to 0; on each lock release from requester k, P <= (k+1) mod N, in both modes.
REQ-022 LOCK: umi_out_valid = umi_in_valid[g]; umi_in_ready = umi_grant & {N{umi_out_ready}}; non-granted ready = 0.
REQ-023 Beat handshake = umi_out_valid & umi_out_ready.
REQ-024 Lock release on handshake with umi_in_last[g] = 1.
REQ-025 On release, if E excluding g is nonzero, load next winner same edge (back-to-back, no idle cycle); else go IDLE.
REQ-026 Released requester g excluded from the back-to-back pick in that cycle only.
REQ-027 Granted requester dropping valid mid-transaction does not release lock.
REQ-028 Mask or mode change during LOCK does not affect current lock; applies at next arbitration.
REQ-029 Idle counter: clears on every handshake and on grant load; increments each LOCK cycle with umi_out_valid = 0; saturates at 2^CW-1.
REQ-030 If timeout != 0 and counter reaches timeout, release lock without handshake, pulse umi_abort one cycle, update P as REQ-021, follow REQ-025 rule.
REQ-031 umi_grant is always zero or one-hot; umi_out_valid = 0 in IDLE.
REQ-032 Simultaneous release and new request from the same requester g: g not regranted that edge; eligible again next arbitration.

Reset
REQ-033 reset asserted: immediately umi_grant = 0, state IDLE, P = 0, counter = 0, umi_abort = 0, umi_out_valid = 0, umi_in_ready = 0.
REQ-034 reset mid-transaction drops lock with no abort pulse; first arbitration after deassertion uses P = 0.

Verification
REQ-035 N=4, mode=0, valid=4'b1010 at cycle 0, out_ready=1, last=1 -> grant 4'b0010 at cycle 1, 4'b1000 at cycle 2, IDLE at cycle 3.
REQ-036 mode=1, all four valid continuously, single-beat packets -> grants cycle 0010? no: 0001, 0010, 0100, 1000, 0001 on consecutive cycles.
REQ-037 Requester 2 granted, 3-beat packet with out_ready toggling 1,0,1,0,1 -> lock held 5 cycles, in_ready[2] mirrors out_ready, release on third handshake.
REQ-038 timeout=4, granted requester drops valid after one beat -> umi_abort pulses 4 cycles after last handshake, grant moves to next eligible or IDLE.
REQ-039 reset asserted mid-lock with grant 4'b0100 -> grant 0 asynchronously; after release with valid=4'b1111, mode=1 -> grant 4'b0001.
REQ-040 mask=4'b0001 with valid=4'b0011, mode=0 -> grant 4'b0010; mask set on granted requester mid-packet -> packet completes.

Source files
------------

// File: rtl/umi_rr_arbiter.sv
// umi_rr_arbiter: N-way packet arbiter with fixed-priority or round-robin
// selection. A grant is held for a whole packet, until the granted
// requester's last beat is accepted. If the holder stays silent for too many
// cycles, an idle timeout breaks the lock. The grant is registered and
// one-hot, so it can drive an external data mux directly.
module umi_rr_arbiter #(
    parameter int N  = 4,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          mode,
    input  logic [N-1:0]  umi_in_mask,
    input  logic [N-1:0]  umi_in_valid,
    input  logic [N-1:0]  umi_in_last,
    output logic [N-1:0]  umi_in_ready,
    input  logic          umi_out_ready,
    output logic          umi_out_valid,
    output logic [N-1:0]  umi_grant,
    input  logic [CW-1:0] timeout,
    output logic          umi_abort
);

    localparam int            PW      = $clog2(N);
    localparam logic [CW-1:0] CNT_MAX = '1;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  grant_q, grant_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] idle_cnt_q, idle_cnt_d;
    logic          abort_q, abort_d;

    logic [N-1:0]  eligible;
    logic [N-1:0]  eligible_next;   // eligible set without the current holder
    logic [PW-1:0] grant_idx;
    logic [PW-1:0] ptr_after;       // pointer value after the holder releases
    logic          handshake;
    logic          last_beat;
    logic          timed_out;
    logic [CW:0]   idle_cnt_inc;

    // Isolate the lowest set bit (v & -v).
    function automatic logic [N-1:0] lowest_one(input logic [N-1:0] v);
        return v & (~v + N'(1));
    endfunction

    // Round-robin: the lowest requester at or above start, falling back to
    // the lowest overall (this is the wrap). Fixed priority: the lowest overall.
    function automatic logic [N-1:0] pick_winner(input logic [N-1:0]  req,
                                                 input logic          rr,
                                                 input logic [PW-1:0] start);
        logic [N-1:0] upper;
        upper = req & ~((N'(1) << start) - N'(1));
        if (rr && (upper != '0)) begin
            return lowest_one(upper);
        end
        return lowest_one(req);
    endfunction

    assign eligible      = umi_in_valid & ~umi_in_mask;
    assign eligible_next = eligible & ~grant_q;
    assign umi_grant     = grant_q;
    assign umi_in_ready  = grant_q & {N{umi_out_ready}};
    assign umi_out_valid = (state_q == LOCK) && ((umi_in_valid & grant_q) != '0);
    assign umi_abort     = abort_q;
    assign handshake     = umi_out_valid & umi_out_ready;
    assign last_beat     = (umi_in_last & grant_q) != '0;
    assign idle_cnt_inc  = {1'b0, idle_cnt_q} + (CW + 1)'(1);
    assign ptr_after     = (grant_idx == PW'(N - 1)) ? '0 : grant_idx + PW'(1);

    // The lock breaks on the idle cycle that brings the silent-cycle count up
    // to timeout. The >= comparison also fires if timeout is lowered mid-lock.
    assign timed_out = (state_q == LOCK) && (timeout != '0) && !umi_out_valid &&
                       (idle_cnt_inc >= {1'b0, timeout});

    // Binary index of the current one-hot holder.
    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_q[i]) begin
                grant_idx = PW'(i);
            end
        end
    end

    // Next-state logic: arbitration from IDLE, plus hold/release/re-grant in LOCK.
    always_comb begin
        // NOTE: every variable gets its hold value first, so no path can leave
        // one unassigned and infer a latch.
        state_d    = state_q;
        grant_d    = grant_q;
        ptr_d      = ptr_q;
        idle_cnt_d = idle_cnt_q;
        abort_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (eligible != '0) begin
                    grant_d    = pick_winner(eligible, mode, ptr_q);
                    idle_cnt_d = '0;
                    state_d    = LOCK;
                end
            end
            LOCK: begin
                if (handshake) begin
                    idle_cnt_d = '0;
                end else if (!umi_out_valid && (idle_cnt_q != CNT_MAX)) begin
                    idle_cnt_d = idle_cnt_inc[CW-1:0];
                end
                if ((handshake && last_beat) || timed_out) begin
                    ptr_d      = ptr_after;
                    abort_d    = timed_out;
                    idle_cnt_d = '0;
                    if (eligible_next != '0) begin
                        grant_d = pick_winner(eligible_next, mode, ptr_after);
                    end else begin
                        grant_d = '0;
                        state_d = IDLE;
                    end
                end
            end
        endcase
    end

    // State register. Reset drops any lock at once and raises no abort.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            ptr_q      <= '0;
            idle_cnt_q <= '0;
            abort_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so every register samples the
            // pre-edge values and the update order inside this block does not matter.
            state_q    <= state_d;
            grant_q    <= grant_d;
            ptr_q      <= ptr_d;
            idle_cnt_q <= idle_cnt_d;
            abort_q    <= abort_d;
        end
    end

endmodule

// File: tb/tb_umi_rr_arbiter.sv
// Testbench for umi_rr_arbiter. It runs three phases: directed vector
// tables, hand-written multi-cycle sequences, then randomized packet traffic
// checked against a cycle-level reference model.
module tb_umi_rr_arbiter;

    localparam int N  = 4;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          mode;
    logic [N-1:0]  umi_in_mask;
    logic [N-1:0]  umi_in_valid;
    logic [N-1:0]  umi_in_last;
    logic [N-1:0]  umi_in_ready;
    logic          umi_out_ready;
    logic          umi_out_valid;
    logic [N-1:0]  umi_grant;
    logic [CW-1:0] timeout;
    logic          umi_abort;

    int n_checks = 0;
    int n_errors = 0;

    umi_rr_arbiter #(.N(N), .CW(CW)) dut (
        .clk           (clk),
        .reset         (reset),
        .mode          (mode),
        .umi_in_mask   (umi_in_mask),
        .umi_in_valid  (umi_in_valid),
        .umi_in_last   (umi_in_last),
        .umi_in_ready  (umi_in_ready),
        .umi_out_ready (umi_out_ready),
        .umi_out_valid (umi_out_valid),
        .umi_grant     (umi_grant),
        .timeout       (timeout),
        .umi_abort     (umi_abort)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic m, input logic [3:0] msk, input logic [3:0] v,
                         input logic [3:0] l, input logic r);
        mode          = m;
        umi_in_mask   = msk;
        umi_in_valid  = v;
        umi_in_last   = l;
        umi_out_ready = r;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    // Cycle-level model: the holder is an index (-1 = none) and silent
    // cycles are counted as an unbounded integer.
    int m_g;
    int m_ptr;
    int m_idle;
    bit m_abort;

    function automatic int first_from(input logic [3:0] e, input int start);
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (start + k) % N;
            if (e[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_g     = -1;
        m_ptr   = 0;
        m_idle  = 0;
        m_abort = 1'b0;
    endtask

    // Advance the model across one rising edge using the inputs now applied.
    task automatic model_step();
        logic [3:0] e;
        bit         done;
        bit         expired;
        e       = umi_in_valid & ~umi_in_mask;
        m_abort = 1'b0;
        if (m_g < 0) begin
            if (e != 4'b0) begin
                m_g    = first_from(e, mode ? m_ptr : 0);
                m_idle = 0;
            end
        end else begin
            done    = umi_in_valid[m_g] && umi_out_ready && umi_in_last[m_g];
            expired = 1'b0;
            if (umi_in_valid[m_g] && umi_out_ready) begin
                m_idle = 0;
            end else if (!umi_in_valid[m_g]) begin
                m_idle++;
                expired = (timeout != 0) && (m_idle >= int'(timeout));
            end
            if (done || expired) begin
                m_abort = expired;
                m_ptr   = (m_g + 1) % N;
                e[m_g]  = 1'b0;
                m_g     = first_from(e, mode ? m_ptr : 0);
                m_idle  = 0;
            end
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic       mode;
        logic [3:0] mask;
        logic [3:0] valid;
        logic [3:0] last;
        logic       ordy;
        logic [3:0] e_grant;
        logic       e_ov;
        logic [3:0] e_rdy;
    } vec_t;

    vec_t vecs[16];

    int            beats[N];
    int            stall[N];
    logic [CW-1:0] tmo_choices[5];

    initial begin
        // Round-robin walk, then a fixed-priority pair, then the mask cases.
        vecs[0]  = '{1'b1, 4'h0, 4'hF, 4'hF, 1'b1, 4'h0, 1'b0, 4'h0};
        vecs[1]  = '{1'b1, 4'h0, 4'hF, 4'hF, 1'b1, 4'h1, 1'b1, 4'h1};
        vecs[2]  = '{1'b1, 4'h0, 4'hF, 4'hF, 1'b1, 4'h2, 1'b1, 4'h2};
        vecs[3]  = '{1'b1, 4'h0, 4'hF, 4'hF, 1'b1, 4'h4, 1'b1, 4'h4};
        vecs[4]  = '{1'b1, 4'h0, 4'hF, 4'hF, 1'b1, 4'h8, 1'b1, 4'h8};
        vecs[5]  = '{1'b1, 4'h0, 4'hF, 4'hF, 1'b1, 4'h1, 1'b1, 4'h1};
        vecs[6]  = '{1'b1, 4'h0, 4'h2, 4'hF, 1'b1, 4'h2, 1'b1, 4'h2};
        vecs[7]  = '{1'b1, 4'h0, 4'h0, 4'hF, 1'b1, 4'h0, 1'b0, 4'h0};
        vecs[8]  = '{1'b0, 4'h0, 4'hA, 4'hF, 1'b1, 4'h0, 1'b0, 4'h0};
        vecs[9]  = '{1'b0, 4'h0, 4'hA, 4'hF, 1'b1, 4'h2, 1'b1, 4'h2};
        vecs[10] = '{1'b0, 4'h0, 4'h8, 4'hF, 1'b1, 4'h8, 1'b1, 4'h8};
        vecs[11] = '{1'b0, 4'h0, 4'h0, 4'hF, 1'b1, 4'h0, 1'b0, 4'h0};
        vecs[12] = '{1'b0, 4'h1, 4'h3, 4'hF, 1'b1, 4'h0, 1'b0, 4'h0};
        vecs[13] = '{1'b0, 4'h3, 4'h3, 4'h0, 1'b1, 4'h2, 1'b1, 4'h2};
        vecs[14] = '{1'b0, 4'h3, 4'h3, 4'h2, 1'b1, 4'h2, 1'b1, 4'h2};
        vecs[15] = '{1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 4'h0, 1'b0, 4'h0};

        tmo_choices = '{8'd0, 8'd1, 8'd3, 8'd5, 8'd255};

        // Reset state, with busy inputs so the checks mean something.
        reset   = 1'b1;
        timeout = '0;
        drive(1'b1, 4'h0, 4'hF, 4'hF, 1'b1);
        @(negedge clk);
        check("rst_grant", umi_grant, 4'h0);
        check("rst_out_valid", umi_out_valid, 1'b0);
        check("rst_in_ready", umi_in_ready, 4'h0);
        check("rst_abort", umi_abort, 1'b0);
        next_cycle();
        reset = 1'b0;

        // Vector table.
        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].mode, vecs[i].mask, vecs[i].valid, vecs[i].last, vecs[i].ordy);
            @(negedge clk);
            check($sformatf("vec%0d_grant", i), umi_grant, vecs[i].e_grant);
            check($sformatf("vec%0d_out_valid", i), umi_out_valid, vecs[i].e_ov);
            check($sformatf("vec%0d_in_ready", i), umi_in_ready, vecs[i].e_rdy);
            check($sformatf("vec%0d_abort", i), umi_abort, 1'b0);
            next_cycle();
        end

        // Three-beat packet from requester 2 with out_ready toggling.
        begin
            int         nbeats;
            logic [4:0] rpat;
            nbeats = 0;
            rpat   = 5'b10101;
            drive(1'b0, 4'h0, 4'h4, 4'h0, 1'b1);
            @(negedge clk);
            check("pkt3_pre_grant", umi_grant, 4'h0);
            next_cycle();
            for (int k = 0; k < 5; k++) begin
                drive(1'b0, 4'h0, 4'h4, (nbeats == 2) ? 4'h4 : 4'h0, rpat[k]);
                @(negedge clk);
                check($sformatf("pkt3_grant_c%0d", k), umi_grant, 4'h4);
                check($sformatf("pkt3_ready_c%0d", k), umi_in_ready,
                      rpat[k] ? 4'h4 : 4'h0);
                check($sformatf("pkt3_ovalid_c%0d", k), umi_out_valid, 1'b1);
                next_cycle();
                if (rpat[k]) nbeats++;
            end
            drive(1'b0, 4'h0, 4'h0, 4'h0, 1'b1);
            @(negedge clk);
            check("pkt3_released", umi_grant, 4'h0);
            next_cycle();
        end

        // Reset while requester 2 holds the lock; the pointer must return to 0.
        drive(1'b0, 4'h0, 4'h4, 4'h0, 1'b1);
        next_cycle();
        drive(1'b1, 4'h0, 4'hF, 4'hF, 1'b0);
        #2;
        check("rstlock_pre_grant", umi_grant, 4'h4);
        reset = 1'b1;
        #1;
        check("rstlock_async_grant", umi_grant, 4'h0);
        check("rstlock_async_ready", umi_in_ready, 4'h0);
        check("rstlock_async_ovalid", umi_out_valid, 1'b0);
        check("rstlock_async_abort", umi_abort, 1'b0);
        next_cycle();
        check("rstlock_held_grant", umi_grant, 4'h0);
        reset         = 1'b0;
        umi_out_ready = 1'b1;
        @(negedge clk);
        check("rstlock_first_idle", umi_grant, 4'h0);
        check("rstlock_no_abort", umi_abort, 1'b0);
        next_cycle();
        @(negedge clk);
        check("rstlock_ptr0_grant", umi_grant, 4'h1);
        next_cycle();
        umi_in_valid = 4'h2;
        @(negedge clk);
        check("rstlock_rr_next", umi_grant, 4'h2);
        next_cycle();
        umi_in_valid = 4'h0;
        @(negedge clk);
        check("rstlock_idle", umi_grant, 4'h0);
        next_cycle();

        // Timeout 4: the holder goes silent after one beat while requester 3 waits.
        timeout = 8'd4;
        drive(1'b0, 4'h0, 4'h2, 4'h0, 1'b1);
        next_cycle();
        @(negedge clk);
        check("tmo4_grant", umi_grant, 4'h2);
        check("tmo4_first_beat", umi_out_valid, 1'b1);
        next_cycle();
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 4'h0, 4'h8, 4'h8, 1'b1);
            @(negedge clk);
            check($sformatf("tmo4_hold_c%0d", k), umi_grant, 4'h2);
            check($sformatf("tmo4_ovalid_c%0d", k), umi_out_valid, 1'b0);
            check($sformatf("tmo4_noabort_c%0d", k), umi_abort, 1'b0);
            next_cycle();
        end
        @(negedge clk);
        check("tmo4_abort", umi_abort, 1'b1);
        check("tmo4_next_grant", umi_grant, 4'h8);
        next_cycle();
        umi_in_valid = 4'h0;
        @(negedge clk);
        check("tmo4_abort_clear", umi_abort, 1'b0);
        check("tmo4_idle", umi_grant, 4'h0);
        next_cycle();

        // Timeout 1: a single silent cycle breaks the lock, and nobody is waiting.
        timeout = 8'd1;
        drive(1'b0, 4'h0, 4'h2, 4'h0, 1'b1);
        next_cycle();
        @(negedge clk);
        check("tmo1_grant", umi_grant, 4'h2);
        next_cycle();
        umi_in_valid = 4'h0;
        @(negedge clk);
        check("tmo1_hold", umi_grant, 4'h2);
        check("tmo1_noabort", umi_abort, 1'b0);
        next_cycle();
        @(negedge clk);
        check("tmo1_abort", umi_abort, 1'b1);
        check("tmo1_idle", umi_grant, 4'h0);
        next_cycle();
        @(negedge clk);
        check("tmo1_abort_clear", umi_abort, 1'b0);
        next_cycle();

        // Randomized packet traffic against the reference model.
        reset = 1'b1;
        drive(1'b0, 4'h0, 4'h0, 4'h0, 1'b0);
        timeout = '0;
        next_cycle();
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < N; i++) begin
            beats[i] = 0;
            stall[i] = 0;
        end
        for (int cyc = 0; cyc < 4000; cyc++) begin
            logic [3:0] exp_g;
            logic       exp_ov;
            if ($urandom_range(0, 29) == 0) mode = ~mode;
            if ($urandom_range(0, 9) == 0) umi_in_mask = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
            if ($urandom_range(0, 49) == 0) timeout = tmo_choices[$urandom_range(0, 4)];
            for (int i = 0; i < N; i++) begin
                if (beats[i] == 0 && $urandom_range(0, 3) == 0) beats[i] = $urandom_range(1, 4);
                if (stall[i] > 0) stall[i]--;
                else if ($urandom_range(0, 19) == 0) stall[i] = $urandom_range(1, 8);
                umi_in_valid[i] = (beats[i] != 0) && (stall[i] == 0);
                umi_in_last[i]  = umi_in_valid[i] ? (beats[i] == 1) : 1'($urandom_range(0, 1));
            end
            umi_out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            exp_g  = (m_g < 0) ? 4'h0 : 4'(1 << m_g);
            exp_ov = (m_g < 0) ? 1'b0 : umi_in_valid[m_g];
            check("rnd_grant", umi_grant, exp_g);
            check("rnd_out_valid", umi_out_valid, exp_ov);
            check("rnd_in_ready", umi_in_ready, umi_out_ready ? exp_g : 4'h0);
            check("rnd_abort", umi_abort, m_abort);
            if (m_g >= 0) begin
                if (umi_in_valid[m_g] && umi_out_ready) beats[m_g]--;
            end
            model_step();
            next_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
